// File: rtl/gate_chk_pkg.sv
// Shared state encodings and the saturating error-count helper for gate_equiv_checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/gate_equiv_checker_settle_timer.sv
// Down-counter that holds each stimulus vector for SETTLE cycles; o_expire marks the last
// APPLY cycle.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= TW'(SETTLE);
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - TW'(1);
  end

  assign o_expire = i_en && (r_cnt == TW'(1));

endmodule

// File: rtl/gate_equiv_checker.sv
// Walks all 2**N_IN vectors, compares two implementations of a function, counts mismatches.
// Optional: define HALT_ON_MISMATCH_EN to stop the run at the first mismatching vector.
module gate_equiv_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic             a_in,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_vld
);

`ifdef HALT_ON_MISMATCH_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [N_IN-1:0]  r_vec;
  logic [CNT_W-1:0] r_err;
  logic [N_IN-1:0]  r_fail_vec;
  logic             r_fail_vld;
  logic             w_load;
  logic             w_expire;
  logic             w_mis;
  logic             w_last;
  logic             w_idle_like;

  assign w_mis       = a_in ^ b_in;
  assign w_last      = &r_vec;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

  settle_timer #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_en     (r_state == S_APPLY),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_APPLY;
          w_load      = 1'b1;
        end
      end
      S_APPLY: begin
        if (w_expire) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if ((HALT && w_mis) || w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_APPLY;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Only the first mismatch is captured; later ones just bump the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec      <= '0;
      r_err      <= '0;
      r_fail_vec <= '0;
      r_fail_vld <= 1'b0;
    end else if (w_idle_like && start) begin
      r_vec      <= '0;
      r_err      <= '0;
      r_fail_vec <= '0;
      r_fail_vld <= 1'b0;
    end else if (r_state == S_CHECK) begin
      if (w_mis) begin
        r_err <= CNT_W'(sat_inc(32'(r_err), 32'({CNT_W{1'b1}})));
        if (!r_fail_vld) begin
          r_fail_vec <= r_vec;
          r_fail_vld <= 1'b1;
        end
      end
      if (w_state_nxt == S_APPLY) r_vec <= r_vec + N_IN'(1);
    end
  end

  assign vec      = r_vec;
  assign busy     = (r_state == S_APPLY) || (r_state == S_CHECK);
  assign done     = (r_state == S_DONE);
  assign pass     = done && (r_err == '0);
  assign err_cnt  = r_err;
  assign fail_vec = r_fail_vec;
  assign fail_vld = r_fail_vld;

endmodule

// File: tb/tb_gate_equiv_checker.sv
// Directed bench: NAND models on a 2-input checker, always-inverted response on a 3-input one.
module tb_gate_equiv_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start = 1'b0;
  logic [1:0] vec;
  logic       a_in, b_in;
  logic       busy, done, pass, fail_vld;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec;
  logic       fault_en = 1'b0;

  logic       start3 = 1'b0;
  logic [2:0] vec3;
  logic       a3, b3;
  logic       busy3, done3, pass3, fail_vld3;
  logic [1:0] err_cnt3;
  logic [2:0] fail_vec3;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // A: NAND built from NOR gates; B: ~a|~b, optionally corrupted at vec 2'b10.
  logic w_n0, w_n1, w_and;
  assign w_n0  = ~(vec[0] | vec[0]);
  assign w_n1  = ~(vec[1] | vec[1]);
  assign w_and = ~(w_n0 | w_n1);
  assign a_in  = ~(w_and | w_and);
  assign b_in  = (~vec[1] | ~vec[0]) ^ (fault_en && vec == 2'b10);

  assign a3 = ^vec3;
  assign b3 = ~a3;

  gate_equiv_checker #(.N_IN(2), .SETTLE(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vec(fail_vec), .fail_vld(fail_vld)
  );

  gate_equiv_checker #(.N_IN(3), .SETTLE(1), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec(vec3), .a_in(a3), .b_in(b3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
    .fail_vec(fail_vec3), .fail_vld(fail_vld3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Start sampling edge is edge 1; returns the edge at which done is first seen high.
  task automatic run(input int sel, input int repulse_at, output int edges,
                     output logic [15:0] vlog, output logic [7:0] err_at1);
    edges = 0;
    vlog  = '0;
    if (sel == 0) start = 1'b1; else start3 = 1'b1;
    @(posedge clk); edges = 1; #1;
    start = 1'b0; start3 = 1'b0;
    err_at1 = (sel == 0) ? err_cnt : 8'(err_cnt3);
    if (busy) vlog = {vlog[13:0], vec};
    while (!((sel == 0) ? done : done3) && edges < 100) begin
      if (edges == repulse_at) begin
        if (sel == 0) start = 1'b1; else start3 = 1'b1;
      end
      @(posedge clk); edges++; #1;
      start = 1'b0; start3 = 1'b0;
      if (sel == 0 && busy) vlog = {vlog[13:0], vec};
    end
    if (edges >= 100) chk("run_timeout", 32'(edges), 32'd0);
  endtask

  int          edges;
  logic [15:0] vlog;
  logic [7:0]  e1;

  initial begin
    #1;
    chk("rst_vec",     32'(vec),      32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_pass",    32'(pass),     32'd0);
    chk("rst_err",     32'(err_cnt),  32'd0);
    chk("rst_failvld", 32'(fail_vld), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Equivalent models
    run(0, -1, edges, vlog, e1);
    chk("s1_done_edge", 32'(edges),    32'd9);
    chk("s1_vec_seq",   32'(vlog),     32'h05AF);
    chk("s1_err",       32'(err_cnt),  32'd0);
    chk("s1_pass",      32'(pass),     32'd1);
    chk("s1_failvld",   32'(fail_vld), 32'd0);
    chk("s1_busy",      32'(busy),     32'd0);

    // Single fault at vec 2'b10
    fault_en = 1'b1;
    run(0, -1, edges, vlog, e1);
    chk("s2_err",      32'(err_cnt),  32'd1);
    chk("s2_failvld",  32'(fail_vld), 32'd1);
    chk("s2_failvec",  32'(fail_vec), 32'd2);
    chk("s2_pass",     32'(pass),     32'd0);
    chk("s2_done",     32'(done),     32'd1);
    chk("s2_busy",     32'(busy),     32'd0);
`ifdef HALT_ON_MISMATCH_EN
    chk("s3_done_edge", 32'(edges),   32'd7);
    chk("s3_vec",       32'(vec),     32'd2);
`else
    chk("s2_done_edge", 32'(edges),   32'd9);
    chk("s2_vec",       32'(vec),     32'd3);
`endif

    // Restart from DONE: counters cleared, full clean run
    fault_en = 1'b0;
    run(0, -1, edges, vlog, e1);
    chk("s6_err_cleared", 32'(e1),       32'd0);
    chk("s6_done_edge",   32'(edges),    32'd9);
    chk("s6_pass",        32'(pass),     32'd1);
    chk("s6_failvld",     32'(fail_vld), 32'd0);

    // start re-pulsed mid-run is ignored
    run(0, 3, edges, vlog, e1);
    chk("s6_repulse_edge", 32'(edges), 32'd9);
    chk("s6_repulse_seq",  32'(vlog),  32'h05AF);

    // Saturating counter, 3-input checker
    run(1, -1, edges, vlog, e1);
    chk("s4_done_edge", 32'(edges),     32'd17);
    chk("s4_err_sat",   32'(err_cnt3),  32'd3);
    chk("s4_failvec",   32'(fail_vec3), 32'd0);
    chk("s4_failvld",   32'(fail_vld3), 32'd1);
    chk("s4_pass",      32'(pass3),     32'd0);

    // Async reset mid-run
    fault_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("s5_busy",    32'(busy),     32'd0);
    chk("s5_vec",     32'(vec),      32'd0);
    chk("s5_done",    32'(done),     32'd0);
    chk("s5_err",     32'(err_cnt),  32'd0);
    chk("s5_failvld", 32'(fail_vld), 32'd0);
    chk("s5_failvec", 32'(fail_vec), 32'd0);
    fault_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("s5_idle_busy", 32'(busy), 32'd0);
    chk("s5_idle_done", 32'(done), 32'd0);
    run(0, -1, edges, vlog, e1);
    chk("s5_done_edge", 32'(edges), 32'd9);
    chk("s5_pass",      32'(pass),  32'd1);
    chk("s5_vec_seq",   32'(vlog),  32'h05AF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
